// File: rtl/bf16_mac_array_if.sv
// Streaming interface for bf16_mac_array:
// bf16 activations in, fp32 per-lane results out.
interface bf16_mac_array_if #(
  parameter int LANES = 4
) ();
  localparam int LW = $clog2(LANES);

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_lane;
  logic [31:0]   out_data;
  logic          out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_lane, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_lane, out_data, out_ovf
  );
endinterface

// File: rtl/bf16_mac_array.sv
// Multi-lane bf16 MAC: shared activation stream, per-lane weight RAM,
// saturating fixed-point accumulators, fp32 results with optional ReLU.
module bf16_mac_array #(
  parameter int  LANES  = 4,
  parameter int  DEPTH  = 1024,
  parameter int  ACC_W  = 48,
  parameter int  FRAC_W = 24,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = $clog2(LANES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [LW-1:0]   wr_lane,
  input  logic [AW-1:0]   wr_addr,
  input  logic [15:0]     wr_data,
  input  logic            start,
  input  logic [AW-1:0]   len,
  input  logic            relu,
  output logic            busy,
  bf16_mac_array_if.slave s
);
  localparam int PW = ACC_W + 16;
  localparam int EB = 268 - FRAC_W;
  localparam int ML = $clog2(ACC_W);
  localparam logic signed [ACC_W-1:0] MAXV =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MAXE =
    {2'b00, {(ACC_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_BIAS, S_DRAIN, S_OUT
  } state_t;

  state_t                   r_st, w_nx;
  logic [AW-1:0]            r_k, r_len;
  logic                     r_relu;
  logic [1:0]               r_dc;
  logic [LW-1:0]            r_lane;
  logic [15:0]              r_mem [LANES][DEPTH];
  logic [15:0]              r_w   [LANES];
  logic [15:0]              r_d;
  logic                     r_v1, r_v2;
  logic signed [ACC_W-1:0]  w_p   [LANES];
  logic signed [ACC_W-1:0]  r_p   [LANES];
  logic [LANES-1:0]         w_pov, r_pov;
  logic signed [ACC_W-1:0]  r_acc [LANES];
  logic signed [ACC_W-1:0]  w_nacc [LANES];
  logic [LANES-1:0]         w_sat, r_ovf;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_start, w_fire, w_iss, w_hs;
  logic [AW-1:0]            w_addr;
  logic [15:0]              w_din;
  logic signed [ACC_W-1:0]  w_a;
  logic                     w_neg;
  logic [ACC_W-1:0]         w_mag, w_norm;
  logic [ML-1:0]            w_m;
  int                       w_ex;
  logic [22:0]              w_man;
  logic [31:0]              w_res;

  assign w_start = (r_st == S_IDLE) && start;
  assign w_fire  = (r_st == S_RUN) && s.in_valid;
  assign w_iss   = w_fire || (r_st == S_BIAS);
  assign w_hs    = (r_st == S_OUT) && s.out_ready;
  assign w_addr  = (r_st == S_BIAS) ? AW'(DEPTH - 1) : r_k;
  assign w_din   = (r_st == S_BIAS) ? 16'h3F80 : s.in_data;

  always_comb begin
    w_nx = r_st;
    case (r_st)
      S_IDLE:  if (start) w_nx = (len == '0) ? S_BIAS : S_RUN;
      S_RUN:   if (w_fire && r_k == r_len - AW'(1)) w_nx = S_BIAS;
      S_BIAS:  w_nx = S_DRAIN;
      S_DRAIN: if (r_dc == 2'd2) w_nx = S_OUT;
      S_OUT:   if (w_hs && r_lane == LW'(LANES - 1)) w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st   <= S_IDLE;
      r_k    <= '0;
      r_len  <= '0;
      r_relu <= 1'b0;
      r_dc   <= '0;
      r_lane <= '0;
    end else begin
      r_st <= w_nx;
      if (w_start) begin
        r_len  <= len;
        r_relu <= relu;
        r_k    <= '0;
      end
      if (w_fire) r_k <= r_k + AW'(1);
      r_dc <= (r_st == S_DRAIN) ? r_dc + 2'd1 : 2'd0;
      if (w_hs) r_lane <= r_lane + LW'(1);
    end
  end

  // Weight RAMs are never reset; write port only live in IDLE.
  always_ff @(posedge clk) begin
    if (wr_en && r_st == S_IDLE) r_mem[wr_lane][wr_addr] <= wr_data;
    for (int l = 0; l < LANES; l++) r_w[l] <= r_mem[l][w_addr];
    r_d <= w_din;
  end

  function automatic logic [ACC_W:0] f_mul(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0]        pm;
    logic signed [11:0] e;
    logic [11:0]        ne;
    logic [PW-1:0]      sh;
    logic [ACC_W-1:0]   mag;
    logic               ov;
    pm  = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    e   = 12'(a[14:7]) + 12'(b[14:7]) - 12'(EB);
    ne  = 12'(-e);
    sh  = '0;
    mag = '0;
    ov  = 1'b0;
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) begin
      mag = '0;
    end else if (e >= 0) begin
      if (e >= 12'(ACC_W - 1)) begin
        ov = 1'b1;
      end else begin
        sh = PW'(pm) << e;
        if (|sh[PW-1:ACC_W-1]) ov = 1'b1;
        else mag = sh[ACC_W-1:0];
      end
    end else if (ne < 12'd16) begin
      mag = ACC_W'(pm >> ne);
    end
    if (ov) mag = MAXV;
    return {ov, (a[15] ^ b[15]) ? -mag : mag};
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++)
      {w_pov[l], w_p[l]} = f_mul(r_w[l], r_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_iss;
      r_v2 <= r_v1;
    end
    r_p   <= w_p;
    r_pov <= w_pov;
  end

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = {r_acc[l][ACC_W-1], r_acc[l]}
            + {r_p[l][ACC_W-1], r_p[l]};
      w_sat[l]  = 1'b0;
      w_nacc[l] = w_sum[ACC_W-1:0];
      if (w_sum > MAXE) begin
        w_nacc[l] = MAXV;
        w_sat[l]  = 1'b1;
      end else if (w_sum < -MAXE) begin
        w_nacc[l] = -MAXV;
        w_sat[l]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
      r_ovf <= '0;
    end else if (r_v2) begin
      for (int l = 0; l < LANES; l++) begin
        r_acc[l] <= w_nacc[l];
        r_ovf[l] <= r_ovf[l] | r_pov[l] | w_sat[l];
      end
    end
  end

  // Magnitude is normalised to bit ACC_W-1; mantissa is truncated.
  always_comb begin
    w_a   = r_acc[r_lane];
    w_neg = w_a[ACC_W-1];
    w_mag = w_neg ? ACC_W'(-w_a) : w_a;
    w_m   = '0;
    for (int i = 0; i < ACC_W; i++)
      if (w_mag[i]) w_m = ML'(i);
    w_ex   = int'(w_m) + 127 - FRAC_W;
    w_norm = w_mag << (ACC_W - 1 - int'(w_m));
    w_man  = 23'(w_norm >> (ACC_W - 24));
    w_res  = '0;
    if (r_ovf[r_lane])
      w_res = w_neg ? 32'hFF7FFFFF : 32'h7F7FFFFF;
    else if (w_mag == '0)
      w_res = '0;
    else if (w_ex <= 0)
      w_res = {w_neg, 31'd0};
    else if (w_ex >= 255)
      w_res = w_neg ? 32'hFF7FFFFF : 32'h7F7FFFFF;
    else
      w_res = {w_neg, 8'(w_ex), w_man};
    if (r_relu && w_neg) w_res = '0;
  end

  assign busy        = (r_st != S_IDLE);
  assign s.in_ready  = (r_st == S_RUN);
  assign s.out_valid = (r_st == S_OUT);
  assign s.out_lane  = r_lane;
  assign s.out_data  = (r_st == S_OUT) ? w_res : '0;
  assign s.out_ovf   = (r_st == S_OUT) && r_ovf[r_lane];
endmodule

// File: tb/tb_bf16_mac_array.sv
// Scoreboard bench for bf16_mac_array: directed runs push expected
// lane results; a negedge monitor pops and compares on each handshake.
module tb_bf16_mac_array;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_lane;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [9:0]  len;
  logic        relu;
  logic        busy;

  bf16_mac_array_if #(.LANES(4)) bus ();

  bf16_mac_array #(
    .LANES(4), .DEPTH(1024), .ACC_W(48), .FRAC_W(24)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_lane(wr_lane),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .relu(relu),
    .busy(busy), .s(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_hs = -1;
  int   fv_cyc = -1;
  logic prev_v = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && !prev_v) fv_cyc <= cyc;
    prev_v <= bus.out_valid;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out lane %0d data %h",
                 bus.out_lane, bus.out_data);
      end else begin
        mon_e = q.pop_front();
        chk("out_lane", 32'(bus.out_lane), 32'(mon_e.lane));
        chk("out_data", bus.out_data, mon_e.data);
        chk("out_ovf", 32'(bus.out_ovf), 32'(mon_e.ovf));
      end
      if (bus.out_lane == 2'd3) last_hs <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int l, int a, logic [15:0] d);
    wr_en   = 1'b1;
    wr_lane = l[1:0];
    wr_addr = a[9:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    for (int l = 0; l < 4; l++) begin
      wr(l, 0, 16'h0000);
      wr(l, 1, 16'h0000);
      wr(l, 1023, 16'h0000);
    end
  endtask

  task automatic set_dot();
    wr(0, 0, 16'h4000);
    wr(0, 1, 16'h3F00);
    wr(0, 1023, 16'h3F80);
  endtask

  task automatic push(logic [31:0] d0, logic [31:0] d1,
                      logic [31:0] d2, logic [31:0] d3, logic ov0);
    q.push_back('{lane: 2'd0, data: d0, ovf: ov0});
    q.push_back('{lane: 2'd1, data: d1, ovf: 1'b0});
    q.push_back('{lane: 2'd2, data: d2, ovf: 1'b0});
    q.push_back('{lane: 2'd3, data: d3, ovf: 1'b0});
  endtask

  task automatic run(int n, logic [15:0] d0, logic [15:0] d1,
                     logic rl, bit tog, int stall, bit cfv);
    int s;
    int t;
    bit ok;
    bus.out_ready = (stall == 0);
    start = 1'b1;
    len   = n[9:0];
    relu  = rl;
    s     = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tog) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? d0 : d1;
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = bus.in_ready;
        tick();
        t++;
      end
      if (!ok) chk("in_ready_timeout", 32'(ok), 32'd1);
    end
    bus.in_valid = 1'b0;
    if (stall > 0) begin
      t = 0;
      while (!bus.out_valid && t < 50) begin
        tick();
        t++;
      end
      chk("stall_wait_valid", 32'(bus.out_valid), 32'd1);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_lane", 32'(bus.out_lane), 32'd0);
        chk("stall_data", bus.out_data, 32'h41000000);
        tick();
      end
      bus.out_ready = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 200);
    chk("busy_fall_cycle", 32'(cyc), 32'(last_hs + 1));
    if (cfv) chk("first_valid_cycle", 32'(fv_cyc), 32'(s + n + 5));
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    wr_en         = 1'b0;
    wr_lane       = '0;
    wr_addr       = '0;
    wr_data       = '0;
    start         = 1'b0;
    len           = '0;
    relu          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_lane", 32'(bus.out_lane), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    tick();

    clr();
    set_dot();
    push(32'h41000000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(2, 16'h4040, 16'h4000, 1'b0, 1'b0, 0, 1'b1);

    clr();
    wr(1, 0, 16'hC040);
    push(32'h0, 32'hC0400000, 32'h0, 32'h0, 1'b0);
    run(1, 16'h3F80, 16'h0, 1'b0, 1'b0, 0, 1'b1);
    push(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    run(1, 16'h3F80, 16'h0, 1'b1, 1'b0, 0, 1'b1);

    clr();
    wr(0, 0, 16'h3F81);
    wr(1, 0, 16'h3E80);
    wr(2, 0, 16'h3F80);
    wr(3, 0, 16'h4040);
    push(32'hC0010000, 32'hBF000000, 32'hC0000000, 32'hC0C00000, 1'b0);
    run(1, 16'hC000, 16'h0, 1'b0, 1'b0, 0, 1'b1);

    clr();
    set_dot();
    push(32'h41000000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(2, 16'h4040, 16'h4000, 1'b0, 1'b1, 5, 1'b0);

    clr();
    wr(0, 0, 16'h4B00);
    wr(0, 1, 16'h4B00);
    push(32'h7F7FFFFF, 32'h0, 32'h0, 32'h0, 1'b1);
    run(2, 16'h3F80, 16'h3F80, 1'b0, 1'b0, 0, 1'b1);
    set_dot();
    push(32'h41000000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(2, 16'h4040, 16'h4000, 1'b0, 1'b0, 0, 1'b1);

    clr();
    wr(0, 0, 16'h0001);
    wr(0, 1023, 16'h3F80);
    push(32'h3F800000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(1, 16'h7F00, 16'h0, 1'b0, 1'b0, 0, 1'b1);
    push(32'h3F800000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(0, 16'h0, 16'h0, 1'b0, 1'b0, 0, 1'b1);

    clr();
    set_dot();
    start = 1'b1;
    len   = 10'd2;
    relu  = 1'b0;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4040;
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    push(32'h41000000, 32'h0, 32'h0, 32'h0, 1'b0);
    run(2, 16'h4040, 16'h4000, 1'b0, 1'b0, 0, 1'b1);

    repeat (5) tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
